// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: state encodings
// and the default instruction-memory geometry.
package imem_port_arbiter_pkg;

   localparam int IMEM_AW = 8;
   localparam int IMEM_DW = 16;

   typedef enum logic [1:0] {
      IMA_BOOT  = 2'd0,
      IMA_RUN   = 2'd1,
      IMA_PATCH = 2'd2
   } ima_state_t;

endpackage

// File: rtl/imem_port_arbiter_rd_tracker.sv
// Tracks the single outstanding fetch (memory latency is one cycle) and holds
// the last fetched instruction between returns.
module imem_rd_tracker
   import imem_port_arbiter_pkg::*;
#(
   parameter int DW = IMEM_DW
) (
   input  logic          mem_clk,
   input  logic          rst_n,
   input  logic          rd_issue,
   input  logic [DW-1:0] mem_rdata,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata
);

   logic          rd_pending_q;
   logic [DW-1:0] rdata_hold_q;

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending_q <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         rd_pending_q <= rd_issue;
         if (rd_pending_q) begin
            rdata_hold_q <= mem_rdata;
         end
      end
   end

   // Pass memory data straight through on the return cycle, hold it afterwards.
   assign if_rvalid = rd_pending_q;
   assign if_rdata  = rd_pending_q ? mem_rdata : rdata_hold_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between CPU fetch (read) and the
// program loader (write); the CPU is held while the loader owns the port.
module imem_port_arbiter
   import imem_port_arbiter_pkg::*;
#(
   parameter int AW        = IMEM_AW,
   parameter int DW        = IMEM_DW,
   parameter int DEPTH     = 256,
   parameter int BOOT_LOAD = 1
) (
   input  logic          mem_clk,
   input  logic          rst_n,
   // Fetch side
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   // Loader side
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ready,
   input  logic          ld_done,
   output logic          ld_err,
   output logic [AW:0]   load_count,
   output logic          cpu_hold,
   // Memory port
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // Debug view of the FSM
   output ima_state_t    dbg_state
);

   // Handshake: a loader write transfers on the cycle ld_valid && ld_ready are
   // both high; a fetch is accepted on the cycle if_gnt is high and its data
   // returns with if_rvalid exactly one cycle later.

   localparam ima_state_t  RESET_STATE = (BOOT_LOAD != 0) ? IMA_BOOT : IMA_RUN;
   localparam logic [AW:0] CNT_MAX     = {1'b1, {AW{1'b0}}};

   ima_state_t  state_q, state_nxt;
   logic [AW:0] count_q;
   logic        err_q;
   logic        wr_fire;
   logic        in_range;
   logic        patch_entry;

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IMA_BOOT, IMA_PATCH: if (ld_done)  state_nxt = IMA_RUN;
         IMA_RUN:             if (ld_valid) state_nxt = IMA_PATCH;
         default:                           state_nxt = RESET_STATE;
      endcase
   end

   assign ld_ready    = (state_q == IMA_BOOT) || (state_q == IMA_PATCH);
   assign cpu_hold    = (state_q != IMA_RUN);
   assign wr_fire     = ld_valid && ld_ready;
   assign in_range    = (32'(ld_addr) < 32'(DEPTH));
   assign patch_entry = (state_q == IMA_RUN) && ld_valid;
   // A pending loader write takes priority over fetch even before PATCH is entered.
   assign if_gnt      = if_req && (state_q == IMA_RUN) && !ld_valid;

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (patch_entry) begin
            count_q <= '0;
         end else if (wr_fire && in_range && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
         end
         if (wr_fire && !in_range) begin
            err_q <= 1'b1;
         end
      end
   end

   assign load_count = count_q;
   assign ld_err     = err_q;
   assign dbg_state  = state_q;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (wr_fire && in_range) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end
   end

   imem_rd_tracker #(.DW(DW)) u_rd_tracker (
      .mem_clk   (mem_clk),
      .rst_n     (rst_n),
      .rd_issue  (if_gnt),
      .mem_rdata (mem_rdata),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata)
   );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench: instance a boots with a loader (DEPTH=16), instance b starts
// in RUN with a preloaded image; both share stimulus.
module tb_imem_port_arbiter;
   import imem_port_arbiter_pkg::*;

   logic        mem_clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        ld_valid;
   logic [7:0]  ld_addr;
   logic [15:0] ld_wdata;
   logic        ld_done;

   logic        if_gnt_a, if_rvalid_a, ld_ready_a, ld_err_a, cpu_hold_a;
   logic [15:0] if_rdata_a, mem_wdata_a, mem_rdata_a;
   logic [8:0]  load_count_a;
   logic        mem_en_a, mem_we_a;
   logic [7:0]  mem_addr_a;
   ima_state_t  state_a;

   logic        if_gnt_b, if_rvalid_b, ld_ready_b, ld_err_b, cpu_hold_b;
   logic [15:0] if_rdata_b, mem_wdata_b;
   logic [15:0] mem_rdata_b = 16'h0000;
   logic [8:0]  load_count_b;
   logic        mem_en_b, mem_we_b;
   logic [7:0]  mem_addr_b;
   ima_state_t  state_b;

   logic [15:0] mem_a [0:255];

   int tests = 0;
   int fails = 0;

   always #5 mem_clk = ~mem_clk;

   imem_port_arbiter #(.AW(8), .DW(16), .DEPTH(16), .BOOT_LOAD(1)) dut_a (
      .mem_clk(mem_clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a),
      .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ld_ready_a), .ld_done(ld_done), .ld_err(ld_err_a),
      .load_count(load_count_a), .cpu_hold(cpu_hold_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .dbg_state(state_a)
   );

   imem_port_arbiter #(.AW(8), .DW(16), .DEPTH(256), .BOOT_LOAD(0)) dut_b (
      .mem_clk(mem_clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b),
      .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ld_ready_b), .ld_done(ld_done), .ld_err(ld_err_b),
      .load_count(load_count_b), .cpu_hold(cpu_hold_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .dbg_state(state_b)
   );

   // Synchronous-read memory behind instance a
   always @(posedge mem_clk) begin
      if (mem_en_a) begin
         if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
         else          mem_rdata_a <= mem_a[mem_addr_a];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
      #12;
      check("rst_state_a",  32'(state_a), 32'(IMA_BOOT));
      check("rst_hold_a",   32'(cpu_hold_a), 32'd1);
      check("rst_count_a",  32'(load_count_a), 32'd0);
      check("rst_err_a",    32'(ld_err_a), 32'd0);
      check("rst_rvalid_a", 32'(if_rvalid_a), 32'd0);
      check("rst_state_b",  32'(state_b), 32'(IMA_RUN));
      check("rst_hold_b",   32'(cpu_hold_b), 32'd0);

      // Release reset; instance b grants from the first cycle, a is in BOOT
      tick();
      rst_n = 1'b1; if_req = 1'b1; if_addr = 8'd5;
      #2;
      check("b_gnt_first", 32'(if_gnt_b), 32'd1);
      check("a_gnt_boot",  32'(if_gnt_a), 32'd0);
      check("a_ready_boot", 32'(ld_ready_a), 32'd1);
      tick();
      if_req = 1'b0;
      #2;
      check("b_rvalid_first", 32'(if_rvalid_b), 32'd1);
      check("a_rvalid_boot",  32'(if_rvalid_a), 32'd0);

      // BOOT load of addresses 0..4
      for (int i = 0; i < 5; i++) begin
         tick();
         ld_valid = 1'b1; ld_addr = 8'(i); ld_wdata = 16'h1234 + 16'(i);
         #2;
         check("boot_wr_en",   32'({mem_en_a, mem_we_a}), 32'd3);
         check("boot_wr_addr", 32'(mem_addr_a), 32'(i));
         check("boot_hold",    32'(cpu_hold_a), 32'd1);
      end
      tick();
      ld_valid = 1'b0; ld_done = 1'b1;
      #2;
      check("boot_count",    32'(load_count_a), 32'd5);
      check("boot_hold_done", 32'(cpu_hold_a), 32'd1);
      tick();
      ld_done = 1'b0; if_req = 1'b1; if_addr = 8'd3;
      #2;
      check("run_hold",  32'(cpu_hold_a), 32'd0);
      check("run_state", 32'(state_a), 32'(IMA_RUN));
      check("fetch3_gnt", 32'(if_gnt_a), 32'd1);
      check("fetch3_mem", 32'({mem_en_a, mem_we_a, mem_addr_a}), {22'd0, 2'b10, 8'd3});
      tick();
      if_req = 1'b0;
      #2;
      check("fetch3_rvalid", 32'(if_rvalid_a), 32'd1);
      check("fetch3_rdata",  32'(if_rdata_a), 32'h1237);
      tick();
      #2;
      check("idle_rvalid", 32'(if_rvalid_a), 32'd0);
      check("idle_rdata_hold", 32'(if_rdata_a), 32'h1237);
      check("idle_mem_en", 32'(mem_en_a), 32'd0);

      // Patch during RUN with fetch held high
      if_req = 1'b1; if_addr = 8'd3;
      tick();
      ld_valid = 1'b1; ld_addr = 8'd8; ld_wdata = 16'hABCD;
      #2;
      check("p1_gnt",    32'(if_gnt_a), 32'd0);
      check("p1_mem_en", 32'(mem_en_a), 32'd0);
      check("p1_rvalid", 32'(if_rvalid_a), 32'd1);
      check("p1_rdata",  32'(if_rdata_a), 32'h1237);
      check("p1_ready",  32'(ld_ready_a), 32'd0);
      tick();
      #2;
      check("p2_hold",  32'(cpu_hold_a), 32'd1);
      check("p2_state", 32'(state_a), 32'(IMA_PATCH));
      check("p2_count", 32'(load_count_a), 32'd0);
      check("p2_wr",    32'({mem_en_a, mem_we_a, mem_addr_a}), {22'd0, 2'b11, 8'd8});
      check("p2_wdata", 32'(mem_wdata_a), 32'hABCD);
      check("p2_rvalid", 32'(if_rvalid_a), 32'd0);

      // Write and ld_done together
      tick();
      ld_addr = 8'd9; ld_wdata = 16'h5A5A; ld_done = 1'b1;
      #2;
      check("p3_count", 32'(load_count_a), 32'd1);
      check("p3_wr",    32'({mem_en_a, mem_we_a, mem_addr_a}), {22'd0, 2'b11, 8'd9});
      tick();
      ld_done = 1'b0; ld_addr = 8'd20; ld_wdata = 16'hDEAD;
      #2;
      check("p4_state", 32'(state_a), 32'(IMA_RUN));
      check("p4_count", 32'(load_count_a), 32'd2);
      check("p4_hold",  32'(cpu_hold_a), 32'd0);
      check("p4_gnt",   32'(if_gnt_a), 32'd0);
      check("p4_mem_en", 32'(mem_en_a), 32'd0);

      // Re-entered PATCH; out-of-range write to 20 with DEPTH=16
      tick();
      #2;
      check("p5_state", 32'(state_a), 32'(IMA_PATCH));
      check("p5_count", 32'(load_count_a), 32'd0);
      check("oor_mem_en", 32'(mem_en_a), 32'd0);
      check("oor_ready",  32'(ld_ready_a), 32'd1);
      check("oor_err_pre", 32'(ld_err_a), 32'd0);
      tick();
      ld_valid = 1'b0; ld_done = 1'b1;
      #2;
      check("oor_err",   32'(ld_err_a), 32'd1);
      check("oor_count", 32'(load_count_a), 32'd0);
      tick();
      ld_done = 1'b0; if_addr = 8'd8;
      #2;
      check("p7_state", 32'(state_a), 32'(IMA_RUN));
      check("p7_err_sticky", 32'(ld_err_a), 32'd1);
      check("fetch8_gnt", 32'(if_gnt_a), 32'd1);
      tick();
      if_addr = 8'd9;
      #2;
      check("fetch8_rdata", 32'({if_rvalid_a, if_rdata_a}), {15'd0, 1'b1, 16'hABCD});
      tick();
      if_req = 1'b0;
      #2;
      check("fetch9_rdata", 32'({if_rvalid_a, if_rdata_a}), {15'd0, 1'b1, 16'h5A5A});

      // Enter PATCH, accept one write, then reset asynchronously
      tick();
      ld_valid = 1'b1; ld_addr = 8'd2; ld_wdata = 16'h0042;
      tick();
      tick();
      ld_valid = 1'b0;
      #1;
      check("pre_rst_state", 32'(state_a), 32'(IMA_PATCH));
      check("pre_rst_count", 32'(load_count_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", 32'(state_a), 32'(IMA_BOOT));
      check("mid_rst_hold",  32'(cpu_hold_a), 32'd1);
      check("mid_rst_err",   32'(ld_err_a), 32'd0);
      check("mid_rst_count", 32'(load_count_a), 32'd0);

      // Reset while instance b has a read in flight
      tick();
      rst_n = 1'b1; if_req = 1'b1; if_addr = 8'd1;
      #2;
      check("b_gnt2", 32'(if_gnt_b), 32'd1);
      tick();
      if_req = 1'b0;
      #1;
      check("b_rvalid2", 32'(if_rvalid_b), 32'd1);
      rst_n = 1'b0;
      #1;
      check("b_rst_rvalid", 32'(if_rvalid_b), 32'd0);
      check("b_rst_state",  32'(state_b), 32'(IMA_RUN));
      check("a_rst_rvalid", 32'(if_rvalid_a), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Owns the single port of the instruction memory (256 x 16, synchronous read) and shares it between two requesters: the CPU IF stage (read) and a program loader (write).
- After reset the CPU is held in BOOT while the loader fills memory.
- In RUN the loader can patch memory at any time; the arbiter freezes fetch, performs the writes, then releases the CPU.
- Sits between cpu top-level fetch logic / debug loader and the memory array.

Parameters:
- AW, 8, address width.
- DW, 16, instruction width.
- DEPTH, 256, implemented words; must be <= 2^AW.
- BOOT_LOAD, 1, selects the reset state: 1 = BOOT, 0 = RUN (preloaded image).

Ports:
- mem_clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request from IF stage.
- if_addr  in  AW  fetch address (PC).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid; one cycle after if_gnt.
- if_rdata  out  DW  fetched instruction.
- ld_valid  in  1  loader write request.
- ld_addr  in  AW  write address.
- ld_wdata  in  DW  write data.
- ld_ready  out  1  loader write accepted when ld_valid && ld_ready.
- ld_done  in  1  single-cycle pulse: end of load/patch session.
- ld_err  out  1  sticky: a write targeted addr >= DEPTH.
- load_count  out  AW+1  accepted writes in the current session, saturating at 2^AW.
- cpu_hold  out  1  stall to the pipeline (freezes PC).
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, one-cycle latency.

Behaviour:
- Reset (async, rst_n=0):
  - state = BOOT if BOOT_LOAD else RUN.
  - cpu_hold = 1 (BOOT) / 0 (RUN).
  - if_rvalid, ld_err, load_count = 0.
  - Any in-flight read is discarded.
- States are BOOT, RUN and PATCH. The state register is the only source of cpu_hold (registered, = state != RUN).
- ld_ready = (state == BOOT || state == PATCH), combinational from state only.
- Write fire = ld_valid && ld_ready.
  - If ld_addr < DEPTH: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata, and load_count increments (saturating).
  - Else the write is dropped (mem_en=0) and ld_err is set; it stays set until reset.
- Fetch grant: if_gnt = if_req && state==RUN && !ld_valid.
  - On grant: mem_en=1, mem_we=0, mem_addr=if_addr.
  - The next cycle, if_rvalid=1 and if_rdata=mem_rdata.
  - if_rdata holds its last valid value otherwise.
- RUN -> PATCH: when ld_valid=1 in RUN.
  - No write and no fetch are issued that cycle.
  - load_count clears.
  - cpu_hold rises the next cycle.
  - A read granted the cycle before still returns if_rvalid normally. There is no drain state because memory latency is 1.
- BOOT/PATCH -> RUN: on ld_done.
  - A write firing in the same cycle is performed first.
  - cpu_hold falls the next cycle; fetch may be granted in the first RUN cycle.
- ld_done in RUN is ignored.
- Entering BOOT (reset) clears load_count.
- Idle cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata are don't-care but driven to 0.
- No read and write ever share a cycle; a write can never collide with an outstanding fetch to the same address.

Decomposition:
- Shared package (cpu.v defines) gains:
  - state encodings: IMA_BOOT=2'd0, IMA_RUN=2'd1, IMA_PATCH=2'd2.
  - IMEM_AW=8, IMEM_DW=16.
- One natural sub-module: imem_rd_tracker. It holds the 1-cycle read-pending flag and the if_rdata hold register, and is cleared by rst_n.
- FSM and port mux stay in the top module.

Test Plan:
- BOOT load: reset with BOOT_LOAD=1. Write addr 0..4 with 16'h1234+i, then pulse ld_done.
  - Required: cpu_hold=1 throughout the load, load_count=5.
  - Required: cpu_hold=0 one cycle after ld_done; a fetch of addr 3 returns 16'h1237 with if_rvalid one cycle after if_gnt.
- Patch during run: if_req held high; raise ld_valid at addr 8, data 16'hABCD.
  - Required: the cycle with ld_valid has if_gnt=0 and mem_en=0, and the prior read still returns if_rvalid.
  - Required: the next cycle has cpu_hold=1 and the write fires. After ld_done, a fetch of 8 returns 16'hABCD.
- Simultaneous ld_valid + ld_done in PATCH: the write to 9 is performed and load_count increments. The state is RUN next cycle, and further ld_valid in that RUN cycle re-enters PATCH.
- Out-of-range write: DEPTH=16, write addr 20.
  - Required: mem_en=0 that cycle, ld_err=1 and stays set across PATCH->RUN, load_count unchanged.
- Reset mid-operation: assert rst_n=0 while a read is pending and state=PATCH.
  - Required immediately: if_rvalid=0, state=BOOT, cpu_hold=1, ld_err=0, load_count=0.
- BOOT_LOAD=0: after reset, state=RUN with cpu_hold=0, and if_gnt follows if_req from the first edge.
